// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that merges N bypass-FIFO streams onto one registered output.
// Grants are held per tenure until the owner stops requesting or hits the burst cap.
module fifo_rr_arbiter #(
    parameter int N         = 3,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 8,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [N-1:0]       i_Req,
    input  logic [N-1:0]       i_Valid,
    input  logic [N*WIDTH-1:0] i_Data,
    output logic [N-1:0]       o_Grant,
    output logic               o_Valid,
    output logic [WIDTH-1:0]   o_Data,
    output logic [IDX_W-1:0]   o_Owner,
    output logic               o_Busy,
    output logic               o_Collision
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       grant_reg, grant_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   last_owner_reg, last_owner_next;
    logic [7:0]         count_reg, count_next;
    logic               valid_reg, valid_next;
    logic [WIDTH-1:0]   data_reg, data_next;
    logic               coll_reg, coll_next;

    logic [WIDTH-1:0]   slice [N];
    logic               beat;
    logic               cap_hit;
    logic               release_now;
    logic [IDX_W-1:0]   base;
    logic [IDX_W-1:0]   pick;
    logic               found;
    int                 idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign slice[gi] = i_Data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan upward from base+1 with wrap; base itself is the last candidate,
    // which is what lets a capped lone requester be re-granted.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        base  = (state_reg == GRANT) ? owner_reg : last_owner_reg;
        for (int off = 1; off <= N; off++) begin
            idx = int'(base) + off;
            if (idx >= N) idx = idx - N;
            if (!found && i_Req[IDX_W'(idx)]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        count_next      = count_reg;
        beat            = (state_reg == GRANT) && i_Valid[owner_reg];
        cap_hit         = (count_reg == 8'(MAX_BURST - 1));
        release_now     = (state_reg == GRANT) && (!i_Req[owner_reg] || (beat && cap_hit));
        valid_next      = beat;
        data_next       = beat ? slice[owner_reg] : data_reg;
        coll_next       = |(i_Valid & ~grant_reg);

        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next        = GRANT;
                    owner_next        = pick;
                    grant_next        = '0;
                    grant_next[pick]  = 1'b1;
                    count_next        = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_owner_next = owner_reg;
                    count_next      = '0;
                    if (found) begin
                        owner_next       = pick;
                        grant_next       = '0;
                        grant_next[pick] = 1'b1;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else if (beat) begin
                    count_next = count_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(N - 1);
            count_reg      <= '0;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            coll_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            count_reg      <= count_next;
            valid_reg      <= valid_next;
            data_reg       <= data_next;
            coll_reg       <= coll_next;
        end
    end

    assign o_Grant     = grant_reg;
    assign o_Valid     = valid_reg;
    assign o_Data      = data_reg;
    assign o_Owner     = owner_reg;
    assign o_Busy      = (state_reg == GRANT);
    assign o_Collision = coll_reg;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a tenure-level model.
module tb_fifo_rr_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           CLK = 1'b0;
    logic           Reset;
    logic [N-1:0]   i_Req;
    logic [N-1:0]   i_Valid;
    logic [N*W-1:0] i_Data;
    logic [N-1:0]   o_Grant;
    logic           o_Valid;
    logic [W-1:0]   o_Data;
    logic [1:0]     o_Owner;
    logic           o_Busy;
    logic           o_Collision;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the bus (-1 = nobody), beats taken this tenure, previous owner.
    int         m_owner = -1;
    int         m_count = 0;
    int         m_last  = N - 1;
    bit         m_valid = 0;
    bit         m_coll  = 0;
    logic [W-1:0] m_data = '0;

    fifo_rr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .CLK(CLK), .Reset(Reset), .i_Req(i_Req), .i_Valid(i_Valid), .i_Data(i_Data),
        .o_Grant(o_Grant), .o_Valid(o_Valid), .o_Data(o_Data), .o_Owner(o_Owner),
        .o_Busy(o_Busy), .o_Collision(o_Collision)
    );

    always #5 CLK = ~CLK;

    function automatic int rr_from(input int from, input logic [N-1:0] req);
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (from + off) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_edge();
        bit beat;
        if (Reset) begin
            m_owner = -1; m_count = 0; m_last = N - 1;
            m_valid = 0;  m_coll = 0;  m_data = '0;
        end else begin
            beat   = (m_owner >= 0) && i_Valid[m_owner];
            m_coll = 0;
            for (int k = 0; k < N; k++)
                if (i_Valid[k] && k != m_owner) m_coll = 1;
            m_valid = beat;
            if (beat) m_data = i_Data[m_owner*W +: W];
            if (m_owner < 0) begin
                if (i_Req != 0) begin
                    m_owner = rr_from(m_last, i_Req);
                    m_count = 0;
                end
            end else if (!i_Req[m_owner] || (beat && m_count == MB - 1)) begin
                m_last  = m_owner;
                m_owner = (i_Req != 0) ? rr_from(m_owner, i_Req) : -1;
                m_count = 0;
            end else if (beat) begin
                m_count++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("grant", 32'(o_Grant), 32'(eg));
        check("busy", 32'(o_Busy), 32'(m_owner >= 0));
        if (m_owner >= 0) check("owner", 32'(o_Owner), 32'(m_owner));
        check("valid", 32'(o_Valid), 32'(m_valid));
        check("data", 32'(o_Data), 32'(m_data));
        check("collision", 32'(o_Collision), 32'(m_coll));
        if (o_Valid) $display("beat data=%02h grant=%03b", o_Data, o_Grant);
    endtask

    task automatic step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] vld,
                        input logic [N*W-1:0] data);
        @(negedge CLK);
        Reset = rst; i_Req = req; i_Valid = vld; i_Data = data;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [N-1:0] req_r;
        logic [N-1:0] vld_r;
        int           nbeats;
        Reset = 1'b1; i_Req = '0; i_Valid = '0; i_Data = '0;

        // Reset values
        step(1'b1, 3'b000, 3'b000, '0);
        step(1'b1, 3'b000, 3'b000, '0);
        check("rst_grant", 32'(o_Grant), 32'h0);
        check("rst_valid", 32'(o_Valid), 32'h0);
        check("rst_data", 32'(o_Data), 32'h0);

        // Single requester streaming 1,2,3
        step(1'b0, 3'b001, 3'b000, '0);
        check("single_grant", 32'(o_Grant), 32'h1);
        for (int d = 1; d <= 3; d++) begin
            step(1'b0, 3'b001, 3'b001, 24'(d));
            check("single_data", 32'(o_Data), 32'(d));
            check("single_coll", 32'(o_Collision), 32'h0);
        end
        step(1'b0, 3'b000, 3'b000, '0);
        check("single_release", 32'(o_Grant), 32'h0);
        check("single_hold", 32'(o_Data), 32'h3);

        // Collision from a non-granted requester
        step(1'b0, 3'b001, 3'b000, '0);
        step(1'b0, 3'b001, 3'b010, 24'h00AA00);
        check("coll_pulse", 32'(o_Collision), 32'h1);
        check("coll_data_held", 32'(o_Data), 32'h3);
        step(1'b0, 3'b001, 3'b000, '0);
        check("coll_one_cycle", 32'(o_Collision), 32'h0);
        step(1'b0, 3'b000, 3'b000, '0);

        // Early drop: owner 1 leaves after 2 beats, index 2 takes over
        step(1'b0, 3'b010, 3'b000, '0);
        check("drop_owner1", 32'(o_Grant), 32'h2);
        step(1'b0, 3'b111, 3'b010, 24'h001100);
        step(1'b0, 3'b111, 3'b010, 24'h002200);
        step(1'b0, 3'b101, 3'b000, '0);
        check("drop_next", 32'(o_Grant), 32'h4);

        // Contention: 4-beat tenures rotating 0,1,2,0 with no gaps
        step(1'b1, 3'b000, 3'b000, '0);
        for (int e = 1; e <= 13; e++) begin
            step(1'b0, 3'b111, 3'b111, 24'($urandom));
            check("cont_busy", 32'(o_Busy), 32'h1);
            if (e == 1)  check("cont_g0", 32'(o_Grant), 32'h1);
            if (e == 5)  check("cont_g1", 32'(o_Grant), 32'h2);
            if (e == 9)  check("cont_g2", 32'(o_Grant), 32'h4);
            if (e == 13) check("cont_g0b", 32'(o_Grant), 32'h1);
            if (e == 9)  check("cont_owner2", 32'(o_Owner), 32'h2);
        end

        // Lone requester hits the cap repeatedly without losing the grant
        step(1'b1, 3'b000, 3'b000, '0);
        step(1'b0, 3'b010, 3'b000, '0);
        nbeats = 0;
        for (int b = 0; b < 10; b++) begin
            step(1'b0, 3'b010, 3'b010, 24'({8'h00, 8'(b + 16), 8'h00}));
            check("lone_grant", 32'(o_Grant), 32'h2);
            if (o_Valid) nbeats++;
        end
        check("lone_beats", 32'(nbeats), 32'd10);

        // Reset during owner 2's third beat
        step(1'b1, 3'b000, 3'b000, '0);
        step(1'b0, 3'b100, 3'b000, '0);
        check("rstmid_owner2", 32'(o_Grant), 32'h4);
        step(1'b0, 3'b100, 3'b100, 24'h510000);
        step(1'b0, 3'b100, 3'b100, 24'h520000);
        step(1'b1, 3'b100, 3'b100, 24'h530000);
        check("rstmid_grant", 32'(o_Grant), 32'h0);
        check("rstmid_valid", 32'(o_Valid), 32'h0);
        step(1'b0, 3'b111, 3'b000, '0);
        check("rstmid_first", 32'(o_Grant), 32'h1);

        // Randomized traffic
        req_r = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(7) == 0) req_r[k] = ~req_r[k];
                if (k == m_owner) vld_r[k] = ($urandom_range(3) != 0);
                else              vld_r[k] = ($urandom_range(7) == 0);
            end
            step(($urandom_range(63) == 0), req_r, vld_r, 24'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter N, default 3: number of SyncFIFO_Bypass requesters, 2..8.
REQ-002 Parameter WIDTH, default 8: data width per requester.
REQ-003 Parameter MAX_BURST, default 8: maximum accepted beats per grant tenure, 1..255.
REQ-004 Derived IDX_W = ceil(log2(N)), minimum 1.
REQ-005 CLK  in  1: single clock, all logic on rising edge.
REQ-006 Reset  in  1: synchronous, active-high reset.
REQ-007 i_Req  in  N: bit k is the request (o_Grant) from FIFO k.
REQ-008 i_Valid  in  N: bit k is the o_Valid of FIFO k.
REQ-009 i_Data  in  N*WIDTH: slice k ([k*WIDTH +: WIDTH]) is the o_Data of FIFO k.
REQ-010 o_Grant  out  N: one-hot or zero grant, drives i_Grant of FIFO k.
REQ-011 o_Valid  out  1: merged output beat valid.
REQ-012 o_Data  out  WIDTH: merged output data.
REQ-013 o_Owner  out  IDX_W: index of current grant holder, valid only when o_Busy=1.
REQ-014 o_Busy  out  1: a grant is held.
REQ-015 o_Collision  out  1: one-cycle pulse, valid beat from a non-granted requester.

Function
REQ-016 o_Grant SHALL be registered and never have more than one bit set.
REQ-017 Two states: IDLE (o_Grant=0, o_Busy=0) and GRANT (o_Grant one-hot, o_Busy=1).
REQ-018 IDLE -> GRANT when i_Req is nonzero. The winner is the first requester at or after index (last_owner+1) mod N, scanning upward with wrap. o_Grant is set on the next edge, one-cycle latency.
REQ-019 A beat is a cycle with o_Grant[owner]=1 and i_Valid[owner]=1. The burst counter increments per beat and clears on each new tenure.
REQ-020 Release condition: i_Req[owner]=0, or a beat occurs while the count equals MAX_BURST-1.
REQ-021 On release with other bits of i_Req set (owner bit excluded when released by i_Req drop), the next winner is chosen round-robin from owner+1 and granted on the same edge, with no idle cycle (GRANT -> GRANT).
REQ-022 On release with no other request, go to IDLE. Exception: on a burst-cap release where only the owner requests, re-grant the owner directly with the counter cleared.
REQ-023 last_owner SHALL update to the owner index at every release. It resets to N-1 so that index 0 has first priority.
REQ-024 o_Valid/o_Data SHALL be registered: o_Valid = i_Valid[owner] AND o_Grant[owner] of the previous cycle, and o_Data = that owner's data slice. Latency is one cycle.
REQ-025 o_Data SHALL hold its last value when o_Valid=0.
REQ-026 o_Collision SHALL pulse one cycle after any cycle where i_Valid[k]=1 and o_Grant[k]=0 for some k. Such beats are dropped from o_Data.
REQ-027 A simultaneous request drop and burst cap SHALL be treated as a single release, with no double advance of last_owner.
REQ-028 MAX_BURST=1 SHALL rotate the grant after every beat.
REQ-029 i_Req bits for indices >= N do not exist. X on unused slices is ignored.

Reset
REQ-030 While Reset=1 at an edge: state IDLE, o_Grant=0, o_Busy=0, o_Owner=0, o_Valid=0, o_Data=0, o_Collision=0, burst counter=0, last_owner=N-1.
REQ-031 Reset asserted mid-tenure SHALL drop the grant on that edge. Any in-flight beat is discarded and o_Valid=0 the following cycle.
REQ-032 The first grant after reset is possible on the first edge with Reset=0 and i_Req nonzero.

Verification (N=3, WIDTH=8, MAX_BURST=4)
REQ-033 Single requester: i_Req=001, FIFO0 streams 1,2,3 -> o_Grant=001 one cycle after request, o_Data=1,2,3 each one cycle after its beat, o_Collision=0.
REQ-034 Contention: i_Req=111 held, all valid every cycle -> grant order 001,010,100,001. Each tenure is 4 beats, handover has zero idle cycles, o_Owner=0,1,2,0.
REQ-035 Early drop: owner 1 drops i_Req after 2 beats with i_Req=101 -> next edge o_Grant=100 (index 2), last_owner=1.
REQ-036 Burst cap, lone requester: i_Req=010 with 10 valid beats -> tenures of 4,4,2 beats. o_Grant remains 010 throughout with counter reset, no gap.
REQ-037 Collision: o_Grant=001 and i_Valid=010 for one cycle -> o_Collision=1 for exactly one cycle and o_Data is unchanged.
REQ-038 Reset mid-burst: Reset=1 during owner 2's 3rd beat -> o_Grant=000 and o_Valid=0 next cycle. After release, i_Req=111 grants index 0 first.
